// File: rtl/phy_stim_if.sv
// PHY TX stimulus/response bundle between phy_stim_checker (master)
// and the PHY pair under test (slave).
interface phy_stim_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 2
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic [LANES-1:0]  active_lane;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [DATA_W-1:0] data_out_synth;
    logic              valid_out_synth;

    modport master (
        output data_in, valid_in, active_lane,
        input  data_out, valid_out, data_out_synth, valid_out_synth
    );

    modport slave (
        input  data_in, valid_in, active_lane,
        output data_out, valid_out, data_out_synth, valid_out_synth
    );
endinterface

// File: rtl/phy_stim_checker.sv
// Phased PHY TX stimulus generator with FIFO scoreboard and behav/synth check.
// Define PHY_STIM_LFSR_EN to source FULL/RAND data from a Galois LFSR.
module phy_stim_checker #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LANES      = 2,
    parameter int unsigned N_RST      = 5,
    parameter int unsigned N_RECIRC   = 10,
    parameter int unsigned N_FULL     = 35,
    parameter int unsigned N_RAND     = 20,
    parameter logic [31:0] INC_RST    = 32'h0321AE4F,
    parameter logic [31:0] INC_RECIRC = 32'h320FE14F,
    parameter logic [31:0] INC_TRAF   = 32'h002F190A,
    parameter int unsigned SB_DEPTH   = 16
) (
    input  logic             clk_2f,
    input  logic             reset_L,
    input  logic             start,
    phy_stim_if.master       phy,
    output logic [2:0]       phase,
    output logic             done,
    output logic [15:0]      err_cnt,
    output logic [15:0]      eqv_cnt,
    output logic             overflow,
    output logic             underflow
);
    localparam int unsigned AW = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [DATA_W-1:0] INC_RST_W    = DATA_W'(INC_RST);
    localparam logic [DATA_W-1:0] INC_RECIRC_W = DATA_W'(INC_RECIRC);
    localparam logic [DATA_W-1:0] INC_TRAF_W   = DATA_W'(INC_TRAF);
    localparam logic [CW-1:0]     SB_FULL      = CW'(SB_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        RECIRC = 3'd2,
        FULL   = 3'd3,
        RAND   = 3'd4,
        DONE   = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              valid_in_q, valid_in_d;
    logic [LANES-1:0]  lane_q, lane_d;
    logic [2:0]        phase_q, phase_d;
    logic              done_q, done_d;
    logic [15:0]       err_q, err_d;
    logic [15:0]       eqv_q, eqv_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] sb_q [SB_DEPTH];
    logic              push, pop, sb_full;

`ifdef PHY_STIM_LFSR_EN
    localparam logic [63:0] TAPS_ALL =
        (DATA_W == 8)  ? 64'hB8 :
        (DATA_W == 16) ? 64'hB400 :
        (DATA_W == 64) ? 64'hD800000000000000 :
                         64'h80200003;
    localparam logic [DATA_W-1:0] TAPS = DATA_W'(TAPS_ALL);
    logic [DATA_W-1:0] lfsr_q, lfsr_d;
`endif

    function automatic int unsigned phase_len(state_e s);
        case (s)
            RST:     phase_len = N_RST;
            RECIRC:  phase_len = N_RECIRC;
            FULL:    phase_len = N_FULL;
            RAND:    phase_len = N_RAND;
            default: phase_len = 0;
        endcase
    endfunction

    // First phase at or after s with a non-zero length; zero-length phases are skipped.
    function automatic state_e first_from(state_e s);
        state_e r;
        r = DONE;
        if (s <= RAND && N_RAND != 0) r = RAND;
        if (s <= FULL && N_FULL != 0) r = FULL;
        if (s <= RECIRC && N_RECIRC != 0) r = RECIRC;
        if (s <= RST && N_RST != 0) r = RST;
        return r;
    endfunction

    function automatic logic [15:0] sat(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_in_d  = data_in_q;
        valid_in_d = 1'b0;
        lane_d     = '0;
        phase_d    = state_q;
        done_d     = (state_q == DONE);
        err_d      = err_q;
        eqv_d      = eqv_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
`ifdef PHY_STIM_LFSR_EN
        lfsr_d     = lfsr_q;
`endif

        sb_full = (count_q == SB_FULL);
        pop     = phy.valid_out && (count_q != '0);
        push    = valid_in_q && (!sb_full || pop);
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;
        if (valid_in_q && sb_full && !pop) ovf_d = 1'b1;

        if (phy.valid_out) begin
            if (count_q == '0) begin
                udf_d = 1'b1;
                err_d = sat(err_q);
            end else if (sb_q[rd_ptr_q] != phy.data_out) begin
                err_d = sat(err_q);
            end
        end

        if (state_q != IDLE &&
            (phy.valid_out != phy.valid_out_synth ||
             (phy.valid_out && phy.data_out != phy.data_out_synth)))
            eqv_d = sat(eqv_q);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = first_from(RST);
                    cnt_d     = '0;
                    data_in_d = '0;
                    err_d     = '0;
                    eqv_d     = '0;
                    ovf_d     = 1'b0;
                    udf_d     = 1'b0;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    count_d   = '0;
`ifdef PHY_STIM_LFSR_EN
                    lfsr_d    = DATA_W'(1);
`endif
                end
            end
            RST:    data_in_d = data_in_q + INC_RST_W;
            RECIRC: data_in_d = data_in_q + INC_RECIRC_W;
            FULL, RAND: begin
                lane_d = '1;
`ifdef PHY_STIM_LFSR_EN
                data_in_d  = lfsr_q;
                lfsr_d     = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
                valid_in_d = (state_q == FULL) ? 1'b1 : lfsr_q[0];
`else
                data_in_d  = data_in_q + INC_TRAF_W;
                valid_in_d = (state_q == FULL) ? 1'b1 : data_in_q[3];
`endif
            end
            default: state_d = IDLE;
        endcase

        if (state_q inside {RST, RECIRC, FULL, RAND}) begin
            if (cnt_q + 32'd1 >= phase_len(state_q)) begin
                cnt_d   = '0;
                state_d = first_from(state_e'(state_q + 3'd1));
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_in_q  <= '0;
            valid_in_q <= 1'b0;
            lane_q     <= '0;
            phase_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
            eqv_q      <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
`ifdef PHY_STIM_LFSR_EN
            lfsr_q     <= DATA_W'(1);
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_in_q  <= data_in_d;
            valid_in_q <= valid_in_d;
            lane_q     <= lane_d;
            phase_q    <= phase_d;
            done_q     <= done_d;
            err_q      <= err_d;
            eqv_q      <= eqv_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
`ifdef PHY_STIM_LFSR_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge clk_2f) begin
        if (push) sb_q[wr_ptr_q] <= data_in_q;
    end

    assign phy.data_in     = data_in_q;
    assign phy.valid_in    = valid_in_q;
    assign phy.active_lane = lane_q;
    assign phase           = phase_q;
    assign done            = done_q;
    assign err_cnt         = err_q;
    assign eqv_cnt         = eqv_q;
    assign overflow        = ovf_q;
    assign underflow       = udf_q;
endmodule

// File: tb/tb_phy_stim_checker.sv
// Bench for phy_stim_checker: 2-cycle PHY model with fault knobs,
// queue of expected stimulus built per run and drained against the DUT.
module tb_phy_stim_checker;
    localparam int DW = 32;
    localparam logic [31:0] INC_RST    = 32'h0321AE4F;
    localparam logic [31:0] INC_RECIRC = 32'h320FE14F;
    localparam logic [31:0] INC_TRAF   = 32'h002F190A;

    logic        clk_2f = 1'b0;
    logic        reset_L = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  phase;
    logic        done;
    logic [15:0] err_cnt, eqv_cnt;
    logic        overflow, underflow;

    int n_chk = 0;
    int n_fail = 0;

    bit corrupt = 0, mask_full = 0, never_valid = 0, force_rst = 0;

    phy_stim_if #(.DATA_W(DW), .LANES(2)) phy ();

    phy_stim_checker #(.SB_DEPTH(4)) dut (
        .clk_2f    (clk_2f),
        .reset_L   (reset_L),
        .start     (start),
        .phy       (phy.master),
        .phase     (phase),
        .done      (done),
        .err_cnt   (err_cnt),
        .eqv_cnt   (eqv_cnt),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk_2f = ~clk_2f;

    // Ideal PHY pair: two-register delay, shared by behav and synth outputs.
    logic [DW-1:0] d1, d2, mdat;
    logic          v1, v2, vo, flip, force_p;
    logic [2:0]    p1, p2;
    int            out_idx;

    always @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            d1 <= '0; d2 <= '0;
            v1 <= 1'b0; v2 <= 1'b0;
            p1 <= '0; p2 <= '0;
            out_idx <= 0;
        end else begin
            d1 <= phy.data_in; d2 <= d1;
            v1 <= phy.valid_in; v2 <= v1;
            p1 <= phase; p2 <= p1;
            if (start) out_idx <= 0;
            else if (v2 && !never_valid) out_idx <= out_idx + 1;
        end
    end

    always_comb begin
        force_p = force_rst && phase == 3'd1 && phy.data_in == INC_RST * 2;
        flip    = corrupt && v2 && out_idx == 2;
        vo      = (v2 && !never_valid) || force_p;
        mdat    = d2 ^ DW'(flip);
        phy.valid_out       = vo;
        phy.data_out        = mdat;
        phy.valid_out_synth = vo && !(mask_full && p2 == 3'd3);
        phy.data_out_synth  = mdat;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  ph;
        logic [31:0] d;
        logic        v;
        logic [1:0]  ln;
    } exp_t;

    exp_t q[$];

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, 64'(phy.data_in), 0);
        check({tag, "_valid"}, 64'(phy.valid_in), 0);
        check({tag, "_lane"}, 64'(phy.active_lane), 0);
        check({tag, "_phase"}, 64'(phase), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_err"}, 64'(err_cnt), 0);
        check({tag, "_eqv"}, 64'(eqv_cnt), 0);
        check({tag, "_ovf"}, 64'(overflow), 0);
        check({tag, "_udf"}, 64'(underflow), 0);
    endtask

    task automatic run(input string nm, input int e_err, input int e_eqv,
                       input int e_ovf, input int e_udf, input bit drains);
        logic [31:0] d;
        int   pushes;
        exp_t e;
        d = 0;
        pushes = 0;
        q.delete();
        for (int i = 0; i < 5; i++) begin
            d = d + INC_RST;
            q.push_back('{3'd1, d, 1'b0, 2'b00});
        end
        for (int i = 0; i < 10; i++) begin
            d = d + INC_RECIRC;
            q.push_back('{3'd2, d, 1'b0, 2'b00});
        end
        for (int i = 0; i < 35; i++) begin
            d = d + INC_TRAF;
            q.push_back('{3'd3, d, 1'b1, 2'b11});
            pushes++;
        end
        for (int i = 0; i < 20; i++) begin
            logic v;
            v = d[3];
            d = d + INC_TRAF;
            q.push_back('{3'd4, d, v, 2'b11});
            if (v) pushes++;
        end
        start = 1'b1;
        @(negedge clk_2f);
        start = 1'b0;
        check({nm, "_d0"}, 64'(phy.data_in), 0);
        for (int i = 1; i <= 70; i++) begin
            @(negedge clk_2f);
            if (q.size() == 0) begin
                check({nm, "_qempty"}, 1, 0);
            end else begin
                e = q.pop_front();
                check($sformatf("%s_data%0d", nm, i), 64'(phy.data_in), 64'(e.d));
                check($sformatf("%s_valid%0d", nm, i), 64'(phy.valid_in), 64'(e.v));
                check($sformatf("%s_lane%0d", nm, i), 64'(phy.active_lane), 64'(e.ln));
                check($sformatf("%s_phase%0d", nm, i), 64'(phase), 64'(e.ph));
            end
            if (i == 70) check({nm, "_done_early"}, 64'(done), 0);
        end
        @(negedge clk_2f);
        check({nm, "_done"}, 64'(done), 1);
        check({nm, "_phase_done"}, 64'(phase), 5);
        repeat (6) @(negedge clk_2f);
        check({nm, "_err"}, 64'(err_cnt), 64'(e_err));
        check({nm, "_eqv"}, 64'(eqv_cnt), 64'(e_eqv));
        check({nm, "_ovf"}, 64'(overflow), 64'(e_ovf));
        check({nm, "_udf"}, 64'(underflow), 64'(e_udf));
        check({nm, "_pops"}, 64'(out_idx), drains ? 64'(pushes) : 0);
    endtask

    initial begin
        repeat (2) @(negedge clk_2f);
        check_idle_outputs("reset");
        reset_L = 1'b1;
        @(negedge clk_2f);

        run("ideal", 0, 0, 0, 0, 1);

        corrupt = 1;
        run("corrupt", 1, 0, 0, 0, 1);
        corrupt = 0;

        mask_full = 1;
        run("synth_mask", 0, 35, 0, 0, 1);
        mask_full = 0;

        never_valid = 1;
        run("no_valid", 0, 0, 1, 0, 0);
        never_valid = 0;

        force_rst = 1;
        run("underflow", 1, 0, 0, 1, 1);
        force_rst = 0;

        start = 1'b1;
        @(negedge clk_2f);
        start = 1'b0;
        repeat (20) @(negedge clk_2f);
        check("midrun_in_full", 64'(phase), 3);
        #2 reset_L = 1'b0;
        #1 check_idle_outputs("midrun_rst");
        @(negedge clk_2f);
        reset_L = 1'b1;
        @(negedge clk_2f);

        run("restart", 0, 0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
